// File: rtl/i2s_dac_tx_pkg.sv
// Shared audio types for the I2S DAC transmit path: sample width, stereo frame
// layout and the channel-edge classification used by the serializer.
package audio_pkg;

   localparam int AUDIO_DATA_W = 16;

   typedef logic signed [AUDIO_DATA_W-1:0] sample_t;

   typedef struct packed {
      sample_t left;
      sample_t right;
   } stereo_frame_t;

   typedef enum logic [1:0] {
      CH_NONE  = 2'd0,
      CH_LEFT  = 2'd1,
      CH_RIGHT = 2'd2
   } ch_edge_e;

endpackage

// File: rtl/i2s_dac_tx_if.sv
// Stereo PCM frame handshake between the sample source and the I2S transmitter.
interface i2s_dac_tx_if;
   import audio_pkg::*;

   sample_t s_data_left;
   sample_t s_data_right;
   logic    s_valid;
   logic    s_ready;

   modport master (output s_data_left, output s_data_right, output s_valid, input s_ready);
   modport slave  (input s_data_left, input s_data_right, input s_valid, output s_ready);

endinterface

// File: rtl/i2s_dac_tx_cdc_sync_edge.sv
// Two-flop synchronizer for a codec-domain pin, plus one history flop so that
// rise/fall strobes are derived purely from clk-domain registers.
module cdc_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q, sync_q, prev_q;
   logic meta_d, sync_d, prev_d;

   // Next-state of the synchronizer chain.
   always_comb begin
      meta_d = async_i;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   // Synchronizer and history registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign sync_o = sync_q;
   assign rise_o = sync_q & ~prev_q;
   assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/i2s_dac_tx.sv
// Slave-mode I2S DAC transmitter: buffers one stereo frame from the handshake
// and shifts it MSB-first onto DACDAT, paced by the codec's BCLK and LRCK.
module i2s_dac_tx
   import audio_pkg::*;
#(
   parameter int DATA_W = AUDIO_DATA_W,
   parameter int CNT_W  = 16
) (
   input  logic              clk_fpga,
   input  logic              rst_n,
   i2s_dac_tx_if.slave       s_if,
   input  logic              audio_BCLK,
   input  logic              audio_DACLRCK,
   output logic              audio_DACDAT,
   output logic              frame_tick,
   output logic              underrun,
   output logic [CNT_W-1:0]  underrun_count
);

   logic bclk_sync_s, bclk_rise_s, bclk_fall_s;
   logic lrck_sync_s, lrck_rise_s, lrck_fall_s;
   logic unused_s;

   cdc_sync_edge u_bclk_sync (
      .clk     (clk_fpga),
      .rst_n   (rst_n),
      .async_i (audio_BCLK),
      .sync_o  (bclk_sync_s),
      .rise_o  (bclk_rise_s),
      .fall_o  (bclk_fall_s)
   );

   cdc_sync_edge u_lrck_sync (
      .clk     (clk_fpga),
      .rst_n   (rst_n),
      .async_i (audio_DACLRCK),
      .sync_o  (lrck_sync_s),
      .rise_o  (lrck_rise_s),
      .fall_o  (lrck_fall_s)
   );

   // LRCK is only meaningful when sampled at a BCLK falling edge.
   assign unused_s = ^{bclk_sync_s, bclk_rise_s, lrck_rise_s, lrck_fall_s};

   stereo_frame_t     hold_q, hold_d;
   stereo_frame_t     frame_q, frame_d;
   logic [DATA_W-1:0] sr_q, sr_d;
   logic              hold_full_q, hold_full_d;
   logic              armed_q, armed_d;
   logic              lrck_prev_q, lrck_prev_d;
   logic              dacdat_q, dacdat_d;
   logic              frame_tick_q, frame_tick_d;
   logic              underrun_q, underrun_d;
   logic [CNT_W-1:0]  underrun_count_q, underrun_count_d;
   logic              xfer_s;
   ch_edge_e          ch_edge_s;

   assign xfer_s = s_if.s_valid & ~hold_full_q;

   // Classify the current BCLK falling edge as left start, right start or neither.
   always_comb begin
      ch_edge_s = CH_NONE;
      if (bclk_fall_s && armed_q) begin
         if (lrck_prev_q && !lrck_sync_s) begin
            ch_edge_s = CH_LEFT;
         end else if (!lrck_prev_q && lrck_sync_s) begin
            ch_edge_s = CH_RIGHT;
         end else begin
            ch_edge_s = CH_NONE;
         end
      end else begin
         ch_edge_s = CH_NONE;
      end
   end

   // Handshake capture, frame loading and serializer next-state.
   always_comb begin
      hold_d           = hold_q;
      hold_full_d      = hold_full_q;
      frame_d          = frame_q;
      sr_d             = sr_q;
      armed_d          = armed_q;
      lrck_prev_d      = lrck_prev_q;
      dacdat_d         = dacdat_q;
      frame_tick_d     = 1'b0;
      underrun_d       = 1'b0;
      underrun_count_d = underrun_count_q;

      if (xfer_s) begin
         hold_d.left  = s_if.s_data_left;
         hold_d.right = s_if.s_data_right;
         hold_full_d  = 1'b1;
      end else begin
         hold_d      = hold_q;
         hold_full_d = hold_full_q;
      end

      // The first falling edge only records LRCK so a high LRCK at reset is not seen as an edge.
      if (bclk_fall_s) begin
         lrck_prev_d = lrck_sync_s;
         armed_d     = 1'b1;
      end else begin
         lrck_prev_d = lrck_prev_q;
         armed_d     = armed_q;
      end

      case (ch_edge_s)
         CH_LEFT: begin
            frame_tick_d = 1'b1;
            if (hold_full_q) begin
               frame_d     = hold_q;
               hold_full_d = 1'b0;
               sr_d        = hold_q.left;
            end else begin
               frame_d    = {(2*DATA_W){1'b0}};
               sr_d       = {DATA_W{1'b0}};
               underrun_d = 1'b1;
               if (underrun_count_q != {CNT_W{1'b1}}) begin
                  underrun_count_d = underrun_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
               end else begin
                  underrun_count_d = underrun_count_q;
               end
            end
         end
         CH_RIGHT: begin
            sr_d = frame_q.right;
         end
         CH_NONE: begin
            if (bclk_fall_s) begin
               dacdat_d = sr_q[DATA_W-1];
               sr_d     = {sr_q[DATA_W-2:0], 1'b0};
            end else begin
               dacdat_d = dacdat_q;
               sr_d     = sr_q;
            end
         end
         default: begin
            dacdat_d = dacdat_q;
            sr_d     = sr_q;
         end
      endcase
   end

   // Datapath and status registers.
   always_ff @(posedge clk_fpga or negedge rst_n) begin
      if (!rst_n) begin
         hold_q           <= {(2*DATA_W){1'b0}};
         hold_full_q      <= 1'b0;
         frame_q          <= {(2*DATA_W){1'b0}};
         sr_q             <= {DATA_W{1'b0}};
         armed_q          <= 1'b0;
         lrck_prev_q      <= 1'b0;
         dacdat_q         <= 1'b0;
         frame_tick_q     <= 1'b0;
         underrun_q       <= 1'b0;
         underrun_count_q <= {CNT_W{1'b0}};
      end else begin
         hold_q           <= hold_d;
         hold_full_q      <= hold_full_d;
         frame_q          <= frame_d;
         sr_q             <= sr_d;
         armed_q          <= armed_d;
         lrck_prev_q      <= lrck_prev_d;
         dacdat_q         <= dacdat_d;
         frame_tick_q     <= frame_tick_d;
         underrun_q       <= underrun_d;
         underrun_count_q <= underrun_count_d;
      end
   end

   assign s_if.s_ready   = ~hold_full_q;
   assign audio_DACDAT   = dacdat_q;
   assign frame_tick     = frame_tick_q;
   assign underrun       = underrun_q;
   assign underrun_count = underrun_count_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx: codec-style BCLK/LRCK (64 BCLK per LRCK),
// DACDAT captured on BCLK rising edges and compared with hand-built slot words.
module tb_i2s_dac_tx;
   import audio_pkg::*;

   logic        clk_fpga = 1'b0;
   logic        rst_n    = 1'b1;
   logic        bclk     = 1'b1;
   logic        lrck     = 1'b1;
   logic        dacdat, frame_tick, underrun;
   logic [15:0] underrun_count;
   logic        dacdat2, tick2, und2;
   logic [1:0]  cnt2;

   int n_tests   = 0;
   int n_fail    = 0;
   int tick_cnt  = 0;
   int und_cnt   = 0;
   int bclk_falls = 0;
   int tick_before;
   int ones;
   logic [31:0] cap_l, cap_r;

   i2s_dac_tx_if s_bus ();
   i2s_dac_tx_if s_bus2 ();

   i2s_dac_tx #(.DATA_W(16), .CNT_W(16)) dut (
      .clk_fpga       (clk_fpga),
      .rst_n          (rst_n),
      .s_if           (s_bus),
      .audio_BCLK     (bclk),
      .audio_DACLRCK  (lrck),
      .audio_DACDAT   (dacdat),
      .frame_tick     (frame_tick),
      .underrun       (underrun),
      .underrun_count (underrun_count)
   );

   // Starved instance with a 2-bit counter to exercise saturation.
   i2s_dac_tx #(.DATA_W(16), .CNT_W(2)) dut_sat (
      .clk_fpga       (clk_fpga),
      .rst_n          (rst_n),
      .s_if           (s_bus2),
      .audio_BCLK     (bclk),
      .audio_DACLRCK  (lrck),
      .audio_DACDAT   (dacdat2),
      .frame_tick     (tick2),
      .underrun       (und2),
      .underrun_count (cnt2)
   );

   always #10 clk_fpga = ~clk_fpga;

   // Codec master: BCLK period 320 ns, LRCK toggles on every 32nd BCLK falling edge.
   initial begin
      #105;
      forever begin
         bclk = 1'b0;
         bclk_falls = bclk_falls + 1;
         if (bclk_falls % 32 == 0) lrck = ~lrck;
         #160;
         bclk = 1'b1;
         #160;
      end
   end

   always @(negedge clk_fpga) begin
      if (frame_tick) tick_cnt <= tick_cnt + 1;
      if (underrun)   und_cnt  <= und_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests = n_tests + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] slot_word(input logic [15:0] w);
      slot_word = {1'b0, w, 15'h0000};
   endfunction

   task automatic send(input logic [15:0] l, input logic [15:0] r);
      int waited;
      waited = 0;
      @(negedge clk_fpga);
      s_bus.s_data_left  = l;
      s_bus.s_data_right = r;
      s_bus.s_valid      = 1'b1;
      while (!s_bus.s_ready && waited < 3000) begin
         @(negedge clk_fpga);
         waited = waited + 1;
      end
      check_eq("send_accept", 32'(s_bus.s_ready), 32'd1);
      @(posedge clk_fpga);
      #1;
      s_bus.s_valid = 1'b0;
   endtask

   task automatic capture_frame(output logic [31:0] l, output logic [31:0] r);
      @(negedge lrck);
      for (int k = 0; k < 32; k++) begin
         @(posedge bclk);
         l[31-k] = dacdat;
      end
      for (int k = 0; k < 32; k++) begin
         @(posedge bclk);
         r[31-k] = dacdat;
      end
   endtask

   initial begin
      s_bus.s_valid       = 1'b0;
      s_bus.s_data_left   = 16'h0000;
      s_bus.s_data_right  = 16'h0000;
      s_bus2.s_valid      = 1'b0;
      s_bus2.s_data_left  = 16'h0000;
      s_bus2.s_data_right = 16'h0000;

      #2 rst_n = 1'b0;
      #5;
      check_eq("rst_dacdat", 32'(dacdat), 32'd0);
      check_eq("rst_ready", 32'(s_bus.s_ready), 32'd1);
      check_eq("rst_tick", 32'(frame_tick), 32'd0);
      check_eq("rst_underrun", 32'(underrun), 32'd0);
      check_eq("rst_count", 32'(underrun_count), 32'd0);
      #196 rst_n = 1'b1;

      // LRCK is high at reset release: no frame start before its first fall.
      send(16'hA5C3, 16'h0F01);
      repeat (4) @(posedge bclk);
      check_eq("no_spurious_tick", 32'(tick_cnt), 32'd0);
      capture_frame(cap_l, cap_r);
      check_eq("a_left", cap_l, slot_word(16'hA5C3));
      check_eq("a_right", cap_r, slot_word(16'h0F01));
      check_eq("a_ticks", 32'(tick_cnt), 32'd1);
      check_eq("a_underruns", 32'(und_cnt), 32'd0);
      check_eq("a_ready", 32'(s_bus.s_ready), 32'd1);
      check_eq("sat_cnt_1", 32'(cnt2), 32'd1);

      // Two frames with nothing offered.
      for (int i = 0; i < 2; i++) begin
         capture_frame(cap_l, cap_r);
         check_eq("b_left_zero", cap_l, 32'h0000_0000);
         check_eq("b_right_zero", cap_r, 32'h0000_0000);
      end
      check_eq("b_underrun_pulses", 32'(und_cnt), 32'd2);
      check_eq("b_underrun_count", 32'(underrun_count), 32'd2);
      check_eq("b_ticks", 32'(tick_cnt), 32'd3);
      check_eq("sat_cnt_3", 32'(cnt2), 32'd3);

      // Back-to-back frames: F1 and F2 go out in order, F3 waits in the holding register.
      fork
         begin
            send(16'h8001, 16'h7FFE);
            check_eq("c_ready_low_after_f1", 32'(s_bus.s_ready), 32'd0);
            send(16'h1234, 16'hFEDC);
            send(16'h00FF, 16'hC3A5);
         end
         begin
            capture_frame(cap_l, cap_r);
            check_eq("c_f1_left", cap_l, slot_word(16'h8001));
            check_eq("c_f1_right", cap_r, slot_word(16'h7FFE));
            capture_frame(cap_l, cap_r);
            check_eq("c_f2_left", cap_l, slot_word(16'h1234));
            check_eq("c_f2_right", cap_r, slot_word(16'hFEDC));
            check_eq("c_f3_held", 32'(s_bus.s_ready), 32'd0);
         end
      join
      capture_frame(cap_l, cap_r);
      check_eq("c_f3_left", cap_l, slot_word(16'h00FF));
      check_eq("c_f3_right", cap_r, slot_word(16'hC3A5));
      check_eq("c_underrun_pulses", 32'(und_cnt), 32'd2);
      check_eq("sat_cnt_saturated", 32'(cnt2), 32'd3);

      // Offer lands on the very cycle the left start is processed.
      fork
         begin
            capture_frame(cap_l, cap_r);
         end
         begin
            @(negedge lrck);
            repeat (2) @(posedge clk_fpga);
            @(negedge clk_fpga);
            s_bus.s_data_left  = 16'h5A5A;
            s_bus.s_data_right = 16'h3C0F;
            s_bus.s_valid      = 1'b1;
            @(posedge clk_fpga);
            #1;
            s_bus.s_valid = 1'b0;
            check_eq("d_underrun_pulse", 32'(underrun), 32'd1);
            check_eq("d_tick_pulse", 32'(frame_tick), 32'd1);
            check_eq("d_frame_stored", 32'(s_bus.s_ready), 32'd0);
         end
      join
      check_eq("d_left_zero", cap_l, 32'h0000_0000);
      check_eq("d_right_zero", cap_r, 32'h0000_0000);
      capture_frame(cap_l, cap_r);
      check_eq("d_next_left", cap_l, slot_word(16'h5A5A));
      check_eq("d_next_right", cap_r, slot_word(16'h3C0F));
      check_eq("d_underrun_count", 32'(underrun_count), 32'd3);

      // Reset in the middle of a left slot.
      send(16'hFFFF, 16'hFFFF);
      @(negedge lrck);
      send(16'h1111, 16'h2222);
      repeat (6) @(posedge bclk);
      check_eq("e_pre_dacdat", 32'(dacdat), 32'd1);
      check_eq("e_pre_ready", 32'(s_bus.s_ready), 32'd0);
      #7 rst_n = 1'b0;
      #1;
      check_eq("e_rst_dacdat", 32'(dacdat), 32'd0);
      check_eq("e_rst_ready", 32'(s_bus.s_ready), 32'd1);
      check_eq("e_rst_count", 32'(underrun_count), 32'd0);
      #50 rst_n = 1'b1;
      tick_before = tick_cnt;
      ones = 0;
      repeat (40) begin
         @(posedge bclk);
         ones = ones + int'(dacdat);
      end
      check_eq("e_quiet_after_rst", 32'(ones), 32'd0);
      check_eq("e_no_tick_before_fall", 32'(tick_cnt), 32'(tick_before));
      send(16'h6C39, 16'h9AA5);
      capture_frame(cap_l, cap_r);
      check_eq("e_resume_left", cap_l, slot_word(16'h6C39));
      check_eq("e_resume_right", cap_r, slot_word(16'h9AA5));
      check_eq("e_resume_tick", 32'(tick_cnt), 32'(tick_before + 1));
      check_eq("e_resume_count", 32'(underrun_count), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
